// File: rtl/nios_system_spi_cs_pkg.sv
// nios_system_spi_cs_pkg: register map, STATUS bit positions and pulse FSM states
package nios_system_spi_cs_pkg;
   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_POLARITY  = 3'd1;
   localparam logic [2:0] ADDR_OUTSET    = 3'd2;
   localparam logic [2:0] ADDR_OUTCLEAR  = 3'd3;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
   localparam logic [2:0] ADDR_PULSE     = 3'd5;
   localparam logic [2:0] ADDR_STATUS    = 3'd6;
   localparam logic [2:0] ADDR_IRQ_EN    = 3'd7;
   localparam int STATUS_BUSY = 0;
   localparam int STATUS_DONE = 1;
   localparam int STATUS_OVR  = 2;
   typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/nios_system_spi_cs_pulse_timer.sv
// nios_system_spi_cs_pulse_timer: one-shot down-counter, expires max(len,1) cycles after start
module nios_system_spi_cs_pulse_timer
   import nios_system_spi_cs_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             expire
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next state: load L-1 on start, count down, expire on the cycle the count is zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      expire  = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            state_d = ACTIVE;
            cnt_d   = (len == '0) ? '0 : len - CNT_W'(1);
         end
      end else if (cnt_q == '0) begin
         state_d = IDLE;
         expire  = 1'b1;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // state and counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == ACTIVE);
endmodule

// File: rtl/nios_system_spi_cs_ctrl.sv
// nios_system_spi_cs_ctrl: Avalon-MM chip-select port with polarity, set/clear and timed pulses
module nios_system_spi_cs_ctrl
   import nios_system_spi_cs_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               CNT_W       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);
   logic             wr, wr_pulse, wr_status, start, busy, expire;
   logic             done_q, done_d, ovr_q, ovr_d, irq_en_q, unused_wd;
   logic [WIDTH-1:0] wd, data_q, data_d, data_cpu, pol_q, mask_q, mask_d;
   logic [CNT_W-1:0] len_q;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign wr_pulse  = wr && address == ADDR_PULSE;
   assign wr_status = wr && address == ADDR_STATUS;
   assign start     = wr_pulse && !busy && wd != '0;
   assign unused_wd = ^writedata;

   nios_system_spi_cs_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .len     (len_q),
      .busy    (busy),
      .expire  (expire)
   );

   // CPU write lands first, then pulse start sets mask bits, then expiry clears them
   always_comb begin
      data_cpu = !wr                       ? data_q :
                 address == ADDR_DATA      ? wd :
                 address == ADDR_OUTSET    ? data_q | wd :
                 address == ADDR_OUTCLEAR  ? data_q & ~wd : data_q;
      data_d   = (data_cpu | (start ? wd : '0)) & ~(expire ? mask_q : '0);
      mask_d   = start ? wd : expire ? '0 : mask_q;
      done_d   = expire | (done_q & ~(wr_status & writedata[STATUS_DONE]));
      ovr_d    = (wr_pulse & busy) | (ovr_q & ~(wr_status & writedata[STATUS_OVR]));
   end

   // register file; sticky flags give set priority over write-one-to-clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= RESET_VALUE;
         pol_q    <= '0;
         len_q    <= '0;
         mask_q   <= '0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         irq_en_q <= 1'b0;
      end else begin
         data_q <= data_d;
         mask_q <= mask_d;
         done_q <= done_d;
         ovr_q  <= ovr_d;
         if (wr && address == ADDR_POLARITY) pol_q <= wd;
         if (wr && address == ADDR_PULSE_LEN) len_q <= writedata[CNT_W-1:0];
         if (wr && address == ADDR_IRQ_EN) irq_en_q <= writedata[0];
      end
   end

   // zero-latency read mux; write-only registers read as zero except PULSE (live mask)
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata = 32'(data_q);
         ADDR_POLARITY:  readdata = 32'(pol_q);
         ADDR_PULSE_LEN: readdata = 32'(len_q);
         ADDR_PULSE:     readdata = 32'(mask_q);
         ADDR_STATUS:    readdata = {29'd0, ovr_q, done_q, busy};
         ADDR_IRQ_EN:    readdata = {31'd0, irq_en_q};
         default:        readdata = '0;
      endcase
   end

   assign out_port = data_q ^ pol_q;
   assign irq      = done_q & irq_en_q;
endmodule

// File: tb/tb_nios_system_spi_cs_ctrl.sv
// tb_nios_system_spi_cs_ctrl: directed self-checking bench for the chip-select/pulse port
module tb_nios_system_spi_cs_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [3:0]  out_port;
   logic        irq;
   int          n_cmp = 0;
   int          n_err = 0;

   nios_system_spi_cs_ctrl #(.WIDTH(4), .CNT_W(16), .RESET_VALUE(4'b0001)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
      address = a;
      #1;
      chk(tag, readdata, exp);
   endtask

   initial begin
      step(2);
      chk("reset_out", 32'(out_port), 32'h1);
      reset_n = 1'b1;
      step(1);
      rd(3'd6, 32'h0, "reset_status");
      chk("reset_irq", 32'(irq), 32'h0);
      rd(3'd0, 32'h1, "reset_data");

      wr(3'd0, 32'hA);
      chk("data_out", 32'(out_port), 32'hA);
      rd(3'd0, 32'hA, "data_rd");
      wr(3'd0, 32'hFFFF_FFF5);
      rd(3'd0, 32'h5, "data_upper_ignored");

      wr(3'd1, 32'hF);
      wr(3'd0, 32'h1);
      chk("pol_out", 32'(out_port), 32'hE);
      wr(3'd2, 32'h4);
      rd(3'd0, 32'h5, "outset");
      wr(3'd3, 32'h1);
      rd(3'd0, 32'h4, "outclear");
      chk("outclear_out", 32'(out_port), 32'hB);
      rd(3'd2, 32'h0, "outset_rd0");
      rd(3'd3, 32'h0, "outclear_rd0");
      rd(3'd1, 32'hF, "pol_rd");

      wr(3'd1, 32'h0);
      wr(3'd0, 32'h0);
      wr(3'd4, 32'h5);
      wr(3'd7, 32'h1);
      rd(3'd4, 32'h5, "len_rd");
      wr(3'd5, 32'h2);
      for (int i = 0; i < 5; i++) begin
         rd(3'd0, 32'h2, $sformatf("p5_high%0d", i));
         rd(3'd6, 32'h1, $sformatf("p5_busy%0d", i));
         step(1);
      end
      rd(3'd0, 32'h0, "p5_low");
      rd(3'd6, 32'h2, "p5_done");
      chk("p5_irq", 32'(irq), 32'h1);
      wr(3'd6, 32'h2);
      chk("w1c_irq", 32'(irq), 32'h0);
      rd(3'd6, 32'h0, "w1c_status");

      wr(3'd4, 32'h0);
      wr(3'd5, 32'h8);
      rd(3'd0, 32'h8, "p0_high");
      step(1);
      rd(3'd0, 32'h0, "p0_low");
      rd(3'd6, 32'h2, "p0_done");
      wr(3'd6, 32'h2);
      wr(3'd5, 32'h0);
      rd(3'd6, 32'h0, "zero_mask_status");
      rd(3'd5, 32'h0, "zero_mask_rd");

      wr(3'd4, 32'd10);
      wr(3'd5, 32'h1);
      step(2);
      wr(3'd5, 32'h2);
      rd(3'd5, 32'h1, "ovr_mask");
      rd(3'd6, 32'h5, "ovr_status");
      rd(3'd0, 32'h1, "ovr_data");
      step(6);
      rd(3'd0, 32'h1, "p10_last_high");
      wr(3'd2, 32'h1);
      rd(3'd0, 32'h0, "expiry_beats_outset");
      rd(3'd6, 32'h6, "p10_status");
      chk("p10_irq", 32'(irq), 32'h1);
      wr(3'd6, 32'h6);
      rd(3'd6, 32'h0, "p10_cleared");

      wr(3'd4, 32'd20);
      wr(3'd5, 32'h4);
      rd(3'd0, 32'h4, "p20_high");
      step(6);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_out", 32'(out_port), 32'h1);
      rd(3'd6, 32'h0, "rst_mid_status");
      chk("rst_mid_irq", 32'(irq), 32'h0);
      step(2);
      reset_n = 1'b1;
      step(25);
      rd(3'd6, 32'h0, "after_rst_status");
      chk("after_rst_irq", 32'(irq), 32'h0);
      chk("after_rst_out", 32'(out_port), 32'h1);
      rd(3'd7, 32'h0, "after_rst_irq_en");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
